// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the 4-way round-robin select arbiter.
package mux4_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arbState_t;

  function automatic logic [NUM_REQ-1:0] oneHot(input logic [1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Requester-side bus of the arbiter: request/data lanes in, grant/select/data out.
interface mux4_rr_arbiter_if #(
  parameter int WIDTH = 8
);
  import mux4_rr_arbiter_pkg::*;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       grant;
  logic [1:0]               sel;
  logic                     busy;
  logic [WIDTH-1:0]         data_out;

  modport master (
    output req, data_in,
    input  grant, sel, busy, data_out
  );

  modport slave (
    input  req, data_in,
    output grant, sel, busy, data_out
  );

endinterface

// File: rtl/mux4_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first set request after 'last', optionally skipping one index.
module rr_pick4
  import mux4_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  input  logic               exclEn,
  input  logic [1:0]         exclIdx,
  output logic               found,
  output logic [1:0]         idx
);

  logic [1:0] cand;

  // Offsets 1..4 wrap naturally in two bits, so 'last' itself is tried last.
  always_comb begin
    found = 1'b0;
    idx   = 2'd0;
    cand  = 2'd0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = last + 2'(k);
      if (!found && req[cand] && !(exclEn && cand == exclIdx)) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 select path with bounded hold time and lane forwarding.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  mux4_rr_arbiter_if.slave bus
);

  localparam bit               PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(MAX_HOLD);

  arbState_t          state;
  logic [1:0]         lastIdx;
  logic [1:0]         selReg;
  logic [NUM_REQ-1:0] grantReg;
  logic               busyReg;
  logic [CNT_W-1:0]   holdCnt;

  logic               ownerReleased;
  logic               othersPending;
  logic               preemptNow;
  logic               handover;
  logic               pickFound;
  logic [1:0]         pickIdx;

  assign ownerReleased = !bus.req[selReg];
  assign othersPending = |(bus.req & ~grantReg);
  assign preemptNow    = PREEMPT_EN && (holdCnt == HOLD_LIM) && othersPending;
  assign handover      = (state == ST_OWN) && (ownerReleased || preemptNow);

  // On handover the search restarts just past the outgoing owner, which is never re-picked.
  rr_pick4 uPick (
    .req     (bus.req),
    .last    ((state == ST_OWN) ? selReg : lastIdx),
    .exclEn  (state == ST_OWN),
    .exclIdx (selReg),
    .found   (pickFound),
    .idx     (pickIdx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      lastIdx  <= 2'd3;
      selReg   <= 2'd0;
      grantReg <= '0;
      busyReg  <= 1'b0;
      holdCnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pickFound) begin
            state    <= ST_OWN;
            selReg   <= pickIdx;
            grantReg <= oneHot(pickIdx);
            busyReg  <= 1'b1;
            holdCnt  <= CNT_W'(1);
          end
        end
        ST_OWN: begin
          if (handover) begin
            lastIdx <= selReg;
            if (pickFound) begin
              selReg   <= pickIdx;
              grantReg <= oneHot(pickIdx);
              holdCnt  <= CNT_W'(1);
            end else begin
              state    <= ST_IDLE;
              grantReg <= '0;
              busyReg  <= 1'b0;
              holdCnt  <= '0;
            end
          end else if (PREEMPT_EN && holdCnt != HOLD_LIM) begin
            holdCnt <= holdCnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.grant    = grantReg;
  assign bus.sel      = selReg;
  assign bus.busy     = busyReg;
  assign bus.data_out = busyReg ? bus.data_in[selReg*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Two arbiters (hold limits 16 and 4) driven in lockstep and compared to a behavioural model.
module tb_mux4_rr_arbiter;
  import mux4_rr_arbiter_pkg::*;

  localparam int WIDTH = 8;

  typedef struct {
    bit owned;
    int owner;
    int last;
    int cnt;
  } refState_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  refState_t   refM [2];
  int          maxHoldOf [2] = '{16, 4};
  int          waitCnt [2][4];
  logic [3:0]  prevGrant [2];
  logic [31:0] lanes;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.WIDTH(WIDTH)) ifA ();
  mux4_rr_arbiter_if #(.WIDTH(WIDTH)) ifB ();

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(16), .CNT_W(5)) dutA (
    .clk (clk),
    .rst (rst),
    .bus (ifA)
  );

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(4), .CNT_W(3)) dutB (
    .clk (clk),
    .rst (rst),
    .bus (ifB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    for (int n = 0; n < 2; n++) begin
      refM[n].owned = 1'b0;
      refM[n].owner = 0;
      refM[n].last  = 3;
      refM[n].cnt   = 0;
      prevGrant[n]  = 4'b0;
      for (int i = 0; i < 4; i++) waitCnt[n][i] = 0;
    end
  endfunction

  // Ownership rules in plain arithmetic: rotate from the previous owner, hand over on drop or timeout.
  function automatic void modelStep(input int n, input logic [3:0] r);
    int  mh;
    int  c;
    int  o;
    bit  found;
    bit  others;
    mh    = maxHoldOf[n];
    found = 1'b0;
    if (!refM[n].owned) begin
      for (int k = 1; k <= 4; k++) begin
        c = (refM[n].last + k) % 4;
        if (!found && r[c]) begin
          found         = 1'b1;
          refM[n].owned = 1'b1;
          refM[n].owner = c;
          refM[n].cnt   = 1;
        end
      end
    end else begin
      o      = refM[n].owner;
      others = (r & ~(4'b0001 << o)) != 4'b0;
      if (!r[o] || (mh != 0 && refM[n].cnt == mh && others)) begin
        refM[n].last = o;
        for (int k = 1; k <= 3; k++) begin
          c = (o + k) % 4;
          if (!found && r[c]) begin
            found         = 1'b1;
            refM[n].owner = c;
            refM[n].cnt   = 1;
          end
        end
        if (!found) begin
          refM[n].owned = 1'b0;
          refM[n].cnt   = 0;
        end
      end else if (mh != 0 && refM[n].cnt < mh) begin
        refM[n].cnt++;
      end
    end
  endfunction

  task automatic compareDut(input int n, input string tag);
    logic [3:0]       g;
    logic [1:0]       s;
    logic             b;
    logic [WIDTH-1:0] d;
    logic [3:0]       expG;
    logic [WIDTH-1:0] expD;
    string            pfx;
    g    = (n == 0) ? ifA.grant    : ifB.grant;
    s    = (n == 0) ? ifA.sel      : ifB.sel;
    b    = (n == 0) ? ifA.busy     : ifB.busy;
    d    = (n == 0) ? ifA.data_out : ifB.data_out;
    expG = refM[n].owned ? (4'b0001 << refM[n].owner) : 4'b0;
    expD = refM[n].owned ? lanes[refM[n].owner*WIDTH +: WIDTH] : '0;
    pfx  = $sformatf("%s[%0d]", tag, n);
    checkOutput({pfx, ".grant"}, 32'(g), 32'(expG));
    checkOutput({pfx, ".sel"}, 32'(s), 32'(refM[n].owner));
    checkOutput({pfx, ".busy"}, 32'(b), 32'(refM[n].owned));
    checkOutput({pfx, ".data"}, 32'(d), 32'(expD));
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input string tag);
    ifA.req     = r;
    ifB.req     = r;
    ifA.data_in = d;
    ifB.data_in = d;
    lanes       = d;
    @(posedge clk);
    modelStep(0, r);
    modelStep(1, r);
    #1;
    compareDut(0, tag);
    compareDut(1, tag);
  endtask

  task automatic doReset();
    rst = 1'b1;
    ifA.req = 4'b0;
    ifB.req = 4'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    compareDut(0, "reset");
    compareDut(1, "reset");
    rst = 1'b0;
  endtask

  // Property checks on the DUT outputs themselves, plus a starvation bound per requester.
  task automatic checkInvariants(input int n, input logic [3:0] r);
    logic [3:0] g;
    logic [1:0] s;
    int         worst;
    g     = (n == 0) ? ifA.grant : ifB.grant;
    s     = (n == 0) ? ifA.sel   : ifB.sel;
    worst = 0;
    checkOutput($sformatf("onehot[%0d]", n), 32'($onehot0(g)), 32'd1);
    if (g != 4'b0) checkOutput($sformatf("selMatch[%0d]", n), 32'(g), 32'(4'b0001 << s));
    for (int i = 0; i < 4; i++) begin
      if (r[i] && !g[i]) begin
        if (g != 4'b0 && g != prevGrant[n]) waitCnt[n][i]++;
      end else begin
        waitCnt[n][i] = 0;
      end
      if (waitCnt[n][i] > worst) worst = waitCnt[n][i];
    end
    checkOutput($sformatf("starve[%0d]", n), 32'(worst > 3), 32'd0);
    prevGrant[n] = g;
  endtask

  initial begin
    logic [31:0] fixedLanes;
    logic [3:0]  r;
    fixedLanes  = 32'hA3A2A1A0;
    ifA.req     = 4'b0;
    ifB.req     = 4'b0;
    ifA.data_in = fixedLanes;
    ifB.data_in = fixedLanes;
    lanes       = fixedLanes;

    $display("[TB] basic grant and no-bubble handover");
    doReset();
    applyStimulus(4'b0101, fixedLanes, "basic");
    checkOutput("basic.firstGrant", 32'(ifA.grant), 32'h1);
    applyStimulus(4'b0100, fixedLanes, "basic");
    checkOutput("basic.handover", 32'(ifA.grant), 32'h4);
    checkOutput("basic.handoverSel", 32'(ifA.sel), 32'd2);

    $display("[TB] round-robin rotation with lane forwarding");
    doReset();
    applyStimulus(4'b1111, fixedLanes, "rotate");
    checkOutput("rotate.d0", 32'(ifA.data_out), 32'hA0);
    applyStimulus(4'b1110, fixedLanes, "rotate");
    checkOutput("rotate.d1", 32'(ifA.data_out), 32'hA1);
    applyStimulus(4'b1101, fixedLanes, "rotate");
    checkOutput("rotate.d2", 32'(ifA.data_out), 32'hA2);
    applyStimulus(4'b1011, fixedLanes, "rotate");
    checkOutput("rotate.d3", 32'(ifA.data_out), 32'hA3);
    applyStimulus(4'b0111, fixedLanes, "rotate");
    checkOutput("rotate.wrap", 32'(ifA.grant), 32'h1);

    $display("[TB] bounded hold preemption");
    doReset();
    applyStimulus(4'b0010, fixedLanes, "hold");
    repeat (3) applyStimulus(4'b1010, fixedLanes, "hold");
    checkOutput("hold.beforeLimit", 32'(ifB.grant), 32'h2);
    applyStimulus(4'b1010, fixedLanes, "hold");
    checkOutput("hold.preempted", 32'(ifB.grant), 32'h8);
    checkOutput("hold.noPreemptA", 32'(ifA.grant), 32'h2);
    repeat (2) applyStimulus(4'b1010, fixedLanes, "hold");
    applyStimulus(4'b0010, fixedLanes, "hold");
    checkOutput("hold.regrant", 32'(ifB.grant), 32'h2);

    $display("[TB] lone requester holds indefinitely");
    doReset();
    repeat (40) applyStimulus(4'b0010, fixedLanes, "lone");
    checkOutput("lone.stillOwned", 32'(ifA.grant), 32'h2);
    applyStimulus(4'b0000, fixedLanes, "lone");
    checkOutput("lone.idleBusy", 32'(ifA.busy), 32'd0);
    checkOutput("lone.idleData", 32'(ifA.data_out), 32'd0);

    $display("[TB] asynchronous reset mid-ownership");
    doReset();
    applyStimulus(4'b1000, fixedLanes, "async");
    checkOutput("async.owned", 32'(ifA.grant), 32'h8);
    #1 rst = 1'b1;
    #1;
    modelReset();
    checkOutput("async.grantCleared", 32'(ifA.grant), 32'h0);
    checkOutput("async.busyCleared", 32'(ifA.busy), 32'd0);
    compareDut(0, "async");
    compareDut(1, "async");
    #1 rst = 1'b0;
    applyStimulus(4'b1111, fixedLanes, "async");
    checkOutput("async.firstAfter", 32'(ifA.grant), 32'h1);

    $display("[TB] randomized traffic");
    doReset();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      r = 4'($urandom_range(0, 15));
      applyStimulus(r, $urandom, "rand");
      checkInvariants(0, r);
      checkInvariants(1, r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
